// File: rtl/cdb_broadcaster.sv
// Common data bus transmit side: per-FU holding buffers, round-robin
// arbitration and a registered one-cycle (tag, value) broadcast.
module cdb_broadcaster #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 5,
    parameter int XLEN   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]  fu_value,
    output logic [NUM_FU-1:0]       fu_ready,
    input  logic                    squash,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [XLEN-1:0]         cdb_value,
    output logic [CNT_W-1:0]        stall_count
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int HC_W  = $clog2(NUM_FU + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_FU - 1);

    logic [NUM_FU-1:0] held_q;
    logic [NUM_FU-1:0] held_d;
    logic [TAG_W-1:0]  hold_tag_q [NUM_FU];
    logic [TAG_W-1:0]  hold_tag_d [NUM_FU];
    logic [XLEN-1:0]   hold_val_q [NUM_FU];
    logic [XLEN-1:0]   hold_val_d [NUM_FU];

    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  rr_ptr_d;

    logic              cdb_valid_q;
    logic              cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [TAG_W-1:0]  cdb_tag_d;
    logic [XLEN-1:0]   cdb_value_q;
    logic [XLEN-1:0]   cdb_value_d;

    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  stall_d;

    logic              gnt_vld;
    logic [PTR_W-1:0]  gnt_idx;
    logic [NUM_FU-1:0] gnt_oh;
    logic [HC_W-1:0]   held_cnt;
    logic              multi_held;
    logic              flush;

    assign flush = reset | squash;

    // Round-robin search of the holding buffers starting at rr_ptr.
    always_comb begin
        int unsigned idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_FU;
            if (!gnt_vld && held_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    // One-hot form of the grant, used for ready and drain.
    always_comb begin
        gnt_oh = '0;
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    // Count occupied buffers; more than one means someone waits this edge.
    always_comb begin
        held_cnt = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            held_cnt = held_cnt + HC_W'(held_q[i]);
        end
        multi_held = (held_cnt > HC_W'(1));
    end

    // A port accepts when empty or when its entry drains this edge.
    always_comb begin
        fu_ready = flush ? '0 : (~held_q | gnt_oh);
    end

    // Buffer next state: drain the winner, then capture new results.
    always_comb begin
        held_d     = held_q;
        hold_tag_d = hold_tag_q;
        hold_val_d = hold_val_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (gnt_oh[i]) begin
                held_d[i] = 1'b0;
            end
            if (fu_valid[i] && fu_ready[i]) begin
                held_d[i]     = |fu_tag[i*TAG_W +: TAG_W];
                hold_tag_d[i] = fu_tag[i*TAG_W +: TAG_W];
                hold_val_d[i] = fu_value[i*XLEN +: XLEN];
            end
        end
    end

    // Broadcast, pointer advance and saturating stall count.
    always_comb begin
        cdb_valid_d = gnt_vld;
        cdb_tag_d   = gnt_vld ? hold_tag_q[gnt_idx] : '0;
        cdb_value_d = gnt_vld ? hold_val_q[gnt_idx] : '0;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == LAST_PTR) ? '0 : gnt_idx + PTR_W'(1);
        end
        stall_d = stall_q;
        if (gnt_vld && multi_held && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Control state; squash clears buffers and bus but keeps ptr/count.
    always_ff @(posedge clock) begin
        if (reset) begin
            held_q      <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            stall_q     <= '0;
        end else if (squash) begin
            held_q      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            held_q      <= held_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            stall_q     <= stall_d;
        end
    end

    // Payload storage; only meaningful where held_q is set.
    always_ff @(posedge clock) begin
        if (!flush) begin
            hold_tag_q <= hold_tag_d;
            hold_val_q <= hold_val_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_value   = cdb_value_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: directed scenarios plus a random run
// compared against a slot-level behavioural model.
module tb_cdb_broadcaster;

    logic         clock = 1'b0;
    logic         reset;
    logic         squash;
    logic [3:0]   fu_valid;
    logic [19:0]  fu_tag;
    logic [127:0] fu_value;
    logic [3:0]   fu_ready;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_value;
    logic [15:0]  stall_count;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cdb_broadcaster dut (
        .clock       (clock),
        .reset       (reset),
        .fu_valid    (fu_valid),
        .fu_tag      (fu_tag),
        .fu_value    (fu_value),
        .fu_ready    (fu_ready),
        .squash      (squash),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .stall_count (stall_count)
    );

    wire [53:0] obs = {cdb_valid, cdb_tag, cdb_value, stall_count};

    // Model: one slot per port, a round-robin start, a bus latch.
    bit          m_held [4];
    logic [4:0]  m_htag [4];
    logic [31:0] m_hval [4];
    int          m_rr;
    int          m_stall;
    logic        m_cv;
    logic [4:0]  m_ct;
    logic [31:0] m_cval;

    function automatic int m_grant();
        for (int k = 0; k < 4; k++)
            if (m_held[(m_rr + k) % 4]) return (m_rr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        int g;
        g = m_grant();
        for (int i = 0; i < 4; i++)
            r[i] = !reset && !squash && (!m_held[i] || g == i);
        return r;
    endfunction

    function automatic logic [53:0] exp_vec();
        return {m_cv, m_ct, m_cval, 16'(m_stall)};
    endfunction

    task automatic model_edge(input logic [3:0] rdy);
        int g;
        int cnt;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_held[i] = 0;
            m_rr = 0; m_stall = 0;
            m_cv = 0; m_ct = 0; m_cval = 0;
        end else if (squash) begin
            for (int i = 0; i < 4; i++) m_held[i] = 0;
            m_cv = 0; m_ct = 0; m_cval = 0;
        end else begin
            g = m_grant();
            cnt = 0;
            for (int i = 0; i < 4; i++) cnt += m_held[i] ? 1 : 0;
            if (g >= 0) begin
                m_cv = 1; m_ct = m_htag[g]; m_cval = m_hval[g];
                m_held[g] = 0;
                m_rr = (g + 1) % 4;
                if (cnt > 1 && m_stall < 65535) m_stall++;
            end else begin
                m_cv = 0; m_ct = 0; m_cval = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (fu_valid[i] && rdy[i]) begin
                    m_held[i] = (fu_tag[i*5 +: 5] != 5'd0);
                    m_htag[i] = fu_tag[i*5 +: 5];
                    m_hval[i] = fu_value[i*32 +: 32];
                end
            end
        end
    endtask

    task automatic cycle();
        logic [3:0] r;
        r = m_ready();
        @(posedge clock);
        model_edge(r);
        #1;
    endtask

    task automatic set_fu(input int i, input logic v,
                          input logic [4:0] t, input logic [31:0] d);
        fu_valid[i] = v;
        fu_tag[i*5 +: 5] = t;
        fu_value[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        fu_valid = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; squash = 1'b0;
        fu_valid = '0; fu_tag = '0; fu_value = '0;
        cycle(); cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 54'd0) begin
            failures++;
            $display("FAIL reset_out got=%h want=0", obs);
        end
        checks++;
        if (fu_ready !== 4'b1111) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1111", fu_ready);
        end
        checks++;
        if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        set_fu(1, 1'b1, 5'd3, 32'd13);
        #1;
        checks++;
        if (fu_ready !== 4'b1111) begin
            failures++;
            $display("FAIL single_ready got=%b want=1111", fu_ready);
        end
        cycle();
        set_fu(1, 1'b0, 5'd0, 32'd0);
        checks++;
        if (cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early got=%b want=0", cdb_valid);
        end
        cycle();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 5'd3, 32'd13}) begin
            failures++;
            $display("FAIL single_bcast got=%b/%0d/%0d want=1/3/13",
                     cdb_valid, cdb_tag, cdb_value);
        end
        cycle();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value} !== 38'd0) begin
            failures++;
            $display("FAIL single_idle got=%b/%0d/%0d want=0/0/0",
                     cdb_valid, cdb_tag, cdb_value);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int i = 0; i < 4; i++)
            set_fu(i, 1'b1, 5'(i + 1), 32'(10 * (i + 1)));
        cycle();
        fu_valid = '0;
        #1;
        checks++;
        if (fu_ready !== 4'b0001) begin
            failures++;
            $display("FAIL four_ready got=%b want=0001", fu_ready);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fu_ready !== m_ready()) begin
                failures++;
                $display("FAIL four_ready_m%0d got=%b want=%b",
                         k, fu_ready, m_ready());
            end
            cycle();
            checks++;
            if ({cdb_valid, cdb_tag, cdb_value} !==
                {1'b1, 5'(k + 1), 32'(10 * (k + 1))}) begin
                failures++;
                $display("FAIL four_bcast%0d got=%b/%0d/%0d want=1/%0d/%0d",
                         k, cdb_valid, cdb_tag, cdb_value, k + 1, 10 * (k + 1));
            end
        end
        checks++;
        if (stall_count !== 16'd3) begin
            failures++;
            $display("FAIL four_stall got=%0d want=3", stall_count);
        end
        cycle();
        checks++;
        if (obs !== exp_vec() || cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL four_idle got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_stream();
        logic [4:0] t0;
        logic [4:0] t2;
        logic [3:0] r;
        int last_src;
        int last2;
        t0 = 5'd8; t2 = 5'd20;
        last_src = -1; last2 = 0;
        set_fu(0, 1'b1, t0, $urandom);
        set_fu(2, 1'b1, t2, $urandom);
        for (int c = 0; c < 16; c++) begin
            #1;
            r = m_ready();
            checks++;
            if (fu_ready !== r) begin
                failures++;
                $display("FAIL stream_ready%0d got=%b want=%b", c, fu_ready, r);
            end
            cycle();
            if (r[0]) begin
                t0 = (t0 == 5'd19) ? 5'd8 : t0 + 5'd1;
                set_fu(0, 1'b1, t0, $urandom);
            end
            if (r[2]) begin
                t2 = (t2 == 5'd31) ? 5'd20 : t2 + 5'd1;
                set_fu(2, 1'b1, t2, $urandom);
            end
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL stream_out%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (cdb_valid && c >= 2) begin
                checks++;
                if ((cdb_tag >= 5'd20 ? 2 : 0) == last_src) begin
                    failures++;
                    $display("FAIL stream_alt%0d got=src%0d want=other",
                             c, last_src);
                end
            end
            if (cdb_valid) last_src = (cdb_tag >= 5'd20) ? 2 : 0;
            if (cdb_valid && cdb_tag >= 5'd20) last2 = c;
            checks++;
            if (c - last2 > 4) begin
                failures++;
                $display("FAIL stream_wait%0d got=%0d want<=4", c, c - last2);
            end
        end
        fu_valid = '0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL stream_drain%0d got=%h want=%h",
                         c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_tag_zero();
        set_fu(3, 1'b1, 5'd0, 32'hdead_beef);
        #1;
        checks++;
        if (fu_ready[3] !== 1'b1) begin
            failures++;
            $display("FAIL tz_ready got=%b want=1", fu_ready[3]);
        end
        cycle();
        set_fu(3, 1'b0, 5'd0, 32'd0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (cdb_valid !== 1'b0) begin
                failures++;
                $display("FAIL tz_valid%0d got=%b want=0", c, cdb_valid);
            end
            cycle();
        end
        checks++;
        if (fu_ready !== 4'b1111 || cdb_valid !== 1'b0) begin
            failures++;
            $display("FAIL tz_after got=%b/%b want=1111/0", fu_ready, cdb_valid);
        end
    endtask

    task automatic test_squash();
        do_reset();
        set_fu(0, 1'b1, 5'd5, 32'd50);
        set_fu(1, 1'b1, 5'd6, 32'd60);
        cycle();
        fu_valid = '0;
        cycle();
        squash = 1'b1;
        set_fu(2, 1'b1, 5'd7, 32'd70);
        #1;
        checks++;
        if (fu_ready !== 4'b0000) begin
            failures++;
            $display("FAIL sq_ready got=%b want=0000", fu_ready);
        end
        cycle();
        squash = 1'b0;
        fu_valid = '0;
        #1;
        checks++;
        if (cdb_valid !== 1'b0 || fu_ready !== 4'b1111) begin
            failures++;
            $display("FAIL sq_clear got=%b/%b want=0/1111", cdb_valid, fu_ready);
        end
        checks++;
        if (stall_count !== 16'd1) begin
            failures++;
            $display("FAIL sq_stall got=%0d want=1", stall_count);
        end
        set_fu(0, 1'b1, 5'd9, 32'd90);
        set_fu(3, 1'b1, 5'd10, 32'd100);
        cycle();
        fu_valid = '0;
        cycle();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 5'd10, 32'd100}) begin
            failures++;
            $display("FAIL sq_first got=%b/%0d/%0d want=1/10/100",
                     cdb_valid, cdb_tag, cdb_value);
        end
        cycle();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 5'd9, 32'd90}) begin
            failures++;
            $display("FAIL sq_second got=%b/%0d/%0d want=1/9/90",
                     cdb_valid, cdb_tag, cdb_value);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++)
            set_fu(i, 1'b1, 5'(11 + i), 32'(110 + i));
        cycle();
        fu_valid = '0;
        cycle(); cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (fu_ready !== 4'b0000 || cdb_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_pre got=%b/%b want=0000/1", fu_ready, cdb_valid);
        end
        cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 54'd0 || fu_ready !== 4'b1111) begin
            failures++;
            $display("FAIL rm_clear got=%h/%b want=0/1111", obs, fu_ready);
        end
        set_fu(1, 1'b1, 5'd21, 32'd210);
        set_fu(3, 1'b1, 5'd23, 32'd230);
        cycle();
        fu_valid = '0;
        cycle();
        checks++;
        if (cdb_tag !== 5'd21 || cdb_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_ptr got=%0d want=21", cdb_tag);
        end
        cycle(); cycle();
    endtask

    task automatic test_random();
        logic [3:0] pend;
        logic [3:0] r;
        do_reset();
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    set_fu(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
                end
                fu_valid[i] = pend[i];
            end
            squash = ($urandom_range(0, 24) == 0);
            reset  = ($urandom_range(0, 79) == 0);
            #1;
            r = m_ready();
            checks++;
            if (fu_ready !== r) begin
                failures++;
                $display("FAIL rnd_ready%0d got=%b want=%b", c, fu_ready, r);
            end
            cycle();
            pend = pend & ~r;
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                $display("FAIL rnd_out%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
        squash = 1'b0;
        reset = 1'b0;
        fu_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_stream();
        test_tag_zero();
        test_squash();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
